// File: rtl/ctrl_pipeline_pkg.sv
// Shared RV32I pipeline types: opcodes, control word, forward-mux encoding,
// stage record and the source-use / forward-select helpers.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic        valid_inst;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    fwd_none = 2'd0,
    fwd_mem  = 2'd1,
    fwd_wb   = 2'd2
  } fwdmux_t;

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // LUI/AUIPC/JAL carry no rs1; only R-type, stores and branches read rs2.
  function automatic logic uses_rs1(rv32i_opcode opcode, logic valid);
    case (opcode)
      op_jalr, op_br, op_load, op_store, op_imm, op_reg, op_csr: return valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(rv32i_opcode opcode, logic valid);
    case (opcode)
      op_reg, op_store, op_br: return valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic fwdmux_t fwd_select(logic [4:0] rs,
                                         logic mem_wr, logic [4:0] mem_rd,
                                         logic wb_wr, logic [4:0] wb_rd);
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) return fwd_mem;
    if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))    return fwd_wb;
    return fwd_none;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Pipeline-control bundle: ID-stage inputs and per-stage control outputs.
interface ctrl_pipeline_if;
  import rv32i_types::*;

  rv32i_control_word id_ctrl;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              mem_stall;
  logic              flush;
  rv32i_control_word ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]        ex_rd, mem_rd, wb_rd;
  logic [4:0]        ex_rs1, ex_rs2;
  logic              hazard_stall;
  fwdmux_t           fwd_a_sel, fwd_b_sel;
  logic [31:0]       retired;

  modport master (
    output id_ctrl, id_rs1, id_rs2, id_rd, mem_stall, flush,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2,
    input  hazard_stall, fwd_a_sel, fwd_b_sel, retired
  );

  modport slave (
    input  id_ctrl, id_rs1, id_rs2, id_rd, mem_stall, flush,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2,
    output hazard_stall, fwd_a_sel, fwd_b_sel, retired
  );

endinterface

// File: rtl/ctrl_pipeline_hazard_detect.sv
// Load-use hazard detection and EX operand forward selection.
module hazard_detect
  import rv32i_types::*;
(
  input  rv32i_opcode id_opcode_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  ex_rs1_i,
  input  logic [4:0]  ex_rs2_i,
  input  logic        mem_load_regfile_i,
  input  logic [4:0]  mem_rd_i,
  input  logic        wb_load_regfile_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic        hazard_stall_o,
  output fwdmux_t     fwd_a_sel_o,
  output fwdmux_t     fwd_b_sel_o
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = uses_rs1(id_opcode_i, id_valid_i) && (ex_rd_i == id_rs1_i);
  assign rs2_hit = uses_rs2(id_opcode_i, id_valid_i) && (ex_rd_i == id_rs2_i);

  // A redirect kills the ID instruction, so it can never be waiting on a load.
  assign hazard_stall_o = !flush_i && ex_mem_read_i && (ex_rd_i != 5'd0)
                          && (rs1_hit || rs2_hit);

  assign fwd_a_sel_o = fwd_select(ex_rs1_i, mem_load_regfile_i, mem_rd_i,
                                  wb_load_regfile_i, wb_rd_i);
  assign fwd_b_sel_o = fwd_select(ex_rs2_i, mem_load_regfile_i, mem_rd_i,
                                  wb_load_regfile_i, wb_rd_i);

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control-word stage registers with stall, flush, bubble insertion
// and a retired-instruction counter.
module ctrl_pipeline
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst,
  ctrl_pipeline_if.slave bus
);

  stage_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [31:0] retired_q, retired_d;
  logic        hazard_stall;

  hazard_detect u_hazard_detect (
    .id_opcode_i        (bus.id_ctrl.opcode),
    .id_valid_i         (bus.id_ctrl.valid_inst),
    .id_rs1_i           (bus.id_rs1),
    .id_rs2_i           (bus.id_rs2),
    .ex_mem_read_i      (ex_q.ctrl.mem_read),
    .ex_rd_i            (ex_q.rd),
    .ex_rs1_i           (ex_q.rs1),
    .ex_rs2_i           (ex_q.rs2),
    .mem_load_regfile_i (mem_q.ctrl.load_regfile),
    .mem_rd_i           (mem_q.rd),
    .wb_load_regfile_i  (wb_q.ctrl.load_regfile),
    .wb_rd_i            (wb_q.rd),
    .flush_i            (bus.flush),
    .hazard_stall_o     (hazard_stall),
    .fwd_a_sel_o        (bus.fwd_a_sel),
    .fwd_b_sel_o        (bus.fwd_b_sel)
  );

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the branches below can infer a latch.
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    retired_d = retired_q;
    if (!bus.mem_stall) begin
      // Invalid ID slots enter as clean bubbles so their don't-care fields never leak out.
      if (bus.flush || hazard_stall || !bus.id_ctrl.valid_inst) begin
        ex_d = STAGE_BUBBLE;
      end else begin
        ex_d = '{ctrl: bus.id_ctrl, rd: bus.id_rd, rs1: bus.id_rs1, rs2: bus.id_rs2};
      end
      mem_d = ex_q;
      wb_d  = mem_q;
      if (wb_q.ctrl.valid_inst) retired_d = retired_q + 32'd1;
    end
  end

  // NOTE: non-blocking assignments so every stage samples its pre-edge
  // neighbour and the pipeline shifts by exactly one stage per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= STAGE_BUBBLE;
      mem_q     <= STAGE_BUBBLE;
      wb_q      <= STAGE_BUBBLE;
      retired_q <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  assign bus.hazard_stall = hazard_stall;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.mem_ctrl     = mem_q.ctrl;
  assign bus.wb_ctrl      = wb_q.ctrl;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.mem_rd       = mem_q.rd;
  assign bus.wb_rd        = wb_q.rd;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.retired      = retired_q;

endmodule
